serial_debug_host: RTL and testbench

On-chip host/initiator for the serial debug chain, seen from the UART side. It takes one 144-bit superframe command, serialises it MSB-byte-first into a `uart` instance's TX FIFO, then collects the 18-byte reply the chain returns. It presents the reply as a 144-bit frame. It sits on the far end of the UART link from `serial_debug_uart`, so a design (or a soft CPU) can drive the debug chain without a PC.

---
 rtl/serial_debug_pkg.sv | 36 +++
 rtl/serial_debug_host.sv | 191 +++++++++++++++++++
 tb/tb_serial_debug_host.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_debug_pkg.sv
// -----------------------------------------------------------------------------
// serial_debug_pkg
//   Shared definitions for the serial debug chain: superframe geometry, field
//   offsets inside a superframe, well-known read commands and the host FSM
//   state encoding.
// -----------------------------------------------------------------------------
package serial_debug_pkg;

   // Superframe geometry: 18 bytes on the wire, sent MSB byte first.
   localparam int SF_BITS  = 144;
   localparam int SF_BYTES = SF_BITS / 8;

   // Field layout inside a superframe.
   localparam int RW_BIT      = 0;   // 1 = write, 0 = read
   localparam int ADDR_LSB    = 1;   // address occupies [15:1]
   localparam int ADDR_W      = 15;
   localparam int PAYLOAD_LSB = 16;  // payload occupies [SF_BITS-1:16]

   localparam logic [ADDR_W-1:0] BCAST_ADDR = 15'h7FFF;

   // Read command byte, carried in payload bits [23:16].
   localparam logic [7:0] READ_CMD_IDENT = 8'h00;
   localparam logic [7:0] READ_CMD_NODE  = 8'hFF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_TX_PUSH,
      ST_TX_GAP,
      ST_RX_WAIT,
      ST_RX_READ,
      ST_RX_HOLD,
      ST_RX_CAPTURE,
      ST_DONE
   } host_state_e;

endpackage

// File: rtl/serial_debug_host.sv
// -----------------------------------------------------------------------------
// serial_debug_host
//   Host/initiator for the serial debug chain, sitting on the UART side.
//   Accepts one superframe command, pushes it MSB byte first into a UART TX
//   FIFO, then collects the same number of reply bytes from the UART RX side
//   and presents them as one superframe. Aborts with rsp_timeout if the link
//   goes quiet for TIMEOUT_CYCLES between reply bytes. Unsolicited RX bytes
//   seen while idle are popped and discarded (stray_byte pulse).
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   cmd_valid/ready     command handshake, cmd_frame is the superframe
//   rsp_valid           one-cycle pulse, rsp_frame / rsp_timeout updated
//   rsp_frame           reply superframe (first byte received in the MSB)
//   rsp_timeout         qualifies rsp_valid: reply incomplete
//   busy                transaction in progress
//   stray_byte          pulse per discarded unsolicited RX byte
//   uart_tx_*           push interface into the UART TX FIFO
//   uart_rx_*           pop interface out of the UART RX FIFO
// -----------------------------------------------------------------------------
module serial_debug_host #(
   parameter int SF_BITS        = serial_debug_pkg::SF_BITS,
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int TIMEOUT_W      = 20
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [SF_BITS-1:0] cmd_frame,
   output logic               rsp_valid,
   output logic [SF_BITS-1:0] rsp_frame,
   output logic               rsp_timeout,
   output logic               busy,
   output logic               stray_byte,
   output logic               uart_tx_start,
   output logic [7:0]         uart_tx_data_in,
   input  logic               uart_tx_fifo_full,
   output logic               uart_rx_read,
   input  logic               uart_rx_ready,
   input  logic [7:0]         uart_rx_byte
);

   import serial_debug_pkg::*;

   localparam logic [4:0]           LAST_IDX = 5'(SF_BITS / 8);
   localparam logic [TIMEOUT_W-1:0] TMO_END  = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

   host_state_e          state_q,   state_d;
   // One shift register serves both directions: after all command bytes are
   // shifted out it is all-zero, so reply bytes shifted in land right-aligned
   // and a partial (timed-out) reply keeps zeros in its upper bits.
   logic [SF_BITS-1:0]   shreg_q,   shreg_d;
   logic [4:0]           idx_q,     idx_d;
   logic [TIMEOUT_W-1:0] timer_q,   timer_d;
   logic                 timeout_q, timeout_d;
   // Set while RX_READ/RX_HOLD are draining a stray byte rather than
   // collecting a reply byte.
   logic                 drain_q,   drain_d;

   // NOTE: state lives only in this block and is updated with non-blocking
   // assignments; every value it stores is computed in the always_comb below.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         shreg_q   <= '0;
         idx_q     <= '0;
         timer_q   <= '0;
         timeout_q <= 1'b0;
         drain_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         idx_q     <= idx_d;
         timer_q   <= timer_d;
         timeout_q <= timeout_d;
         drain_q   <= drain_d;
      end
   end

   // NOTE: every signal written here gets a default first, so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_d         = state_q;
      shreg_d         = shreg_q;
      idx_d           = idx_q;
      timer_d         = timer_q;
      timeout_d       = timeout_q;
      drain_d         = drain_q;
      cmd_ready       = 1'b0;
      busy            = 1'b0;
      rsp_valid       = 1'b0;
      stray_byte      = 1'b0;
      uart_tx_start   = 1'b0;
      uart_tx_data_in = 8'h00;
      uart_rx_read    = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            // Never accept a command while a stray byte is pending, or it
            // would be mistaken for the first reply byte.
            cmd_ready = !uart_rx_ready;
            if (uart_rx_ready) begin
               drain_d = 1'b1;
               state_d = ST_RX_READ;
            end else if (cmd_valid) begin
               shreg_d   = cmd_frame;
               idx_d     = '0;
               timeout_d = 1'b0;
               drain_d   = 1'b0;
               state_d   = ST_TX_PUSH;
            end
         end

         ST_TX_PUSH: begin
            busy            = 1'b1;
            uart_tx_data_in = shreg_q[SF_BITS-1 -: 8];
            if (!uart_tx_fifo_full) begin
               uart_tx_start = 1'b1;
               shreg_d       = {shreg_q[SF_BITS-9:0], 8'h00};
               idx_d         = idx_q + 5'd1;
               state_d       = ST_TX_GAP;
            end
         end

         // Dead cycle so uart_tx_fifo_full reflects the push just made.
         ST_TX_GAP: begin
            busy = 1'b1;
            if (idx_q < LAST_IDX) begin
               state_d = ST_TX_PUSH;
            end else begin
               idx_d   = '0;
               timer_d = '0;
               state_d = ST_RX_WAIT;
            end
         end

         ST_RX_WAIT: begin
            busy = 1'b1;
            if (uart_rx_ready) begin
               state_d = ST_RX_READ;
            end else if (timer_q == TMO_END) begin
               timeout_d = 1'b1;
               state_d   = ST_DONE;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end

         ST_RX_READ: begin
            busy         = !drain_q;
            uart_rx_read = 1'b1;
            state_d      = ST_RX_HOLD;
         end

         // Gives the UART a cycle to present the popped byte and drop
         // uart_rx_ready if its FIFO is now empty.
         ST_RX_HOLD: begin
            busy = !drain_q;
            if (drain_q) begin
               stray_byte = 1'b1;
               drain_d    = 1'b0;
               state_d    = ST_IDLE;
            end else begin
               state_d = ST_RX_CAPTURE;
            end
         end

         ST_RX_CAPTURE: begin
            busy    = 1'b1;
            shreg_d = {shreg_q[SF_BITS-9:0], uart_rx_byte};
            idx_d   = idx_q + 5'd1;
            timer_d = '0;
            state_d = (idx_q + 5'd1 == LAST_IDX) ? ST_DONE : ST_RX_WAIT;
         end

         ST_DONE: begin
            rsp_valid = 1'b1;
            state_d   = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // rsp_frame shows the shift register directly; it only carries a
   // meaningful reply from the rsp_valid pulse until the next command.
   assign rsp_frame   = shreg_q;
   assign rsp_timeout = timeout_q;

endmodule

// File: tb/tb_serial_debug_host.sv
module tb_serial_debug_host;

   localparam int SFB = 144;
   localparam int TMO = 200;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           cmd_valid = 1'b0;
   logic           cmd_ready;
   logic [SFB-1:0] cmd_frame = '0;
   logic           rsp_valid;
   logic [SFB-1:0] rsp_frame;
   logic           rsp_timeout;
   logic           busy;
   logic           stray_byte;
   logic           uart_tx_start;
   logic [7:0]     uart_tx_data_in;
   logic           uart_tx_fifo_full = 1'b0;
   logic           uart_rx_read;
   logic           uart_rx_ready;
   logic [7:0]     uart_rx_byte;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   serial_debug_host #(
      .SF_BITS        (SFB),
      .TIMEOUT_CYCLES (TMO),
      .TIMEOUT_W      (20)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .cmd_valid         (cmd_valid),
      .cmd_ready         (cmd_ready),
      .cmd_frame         (cmd_frame),
      .rsp_valid         (rsp_valid),
      .rsp_frame         (rsp_frame),
      .rsp_timeout       (rsp_timeout),
      .busy              (busy),
      .stray_byte        (stray_byte),
      .uart_tx_start     (uart_tx_start),
      .uart_tx_data_in   (uart_tx_data_in),
      .uart_tx_fifo_full (uart_tx_fifo_full),
      .uart_rx_read      (uart_rx_read),
      .uart_rx_ready     (uart_rx_ready),
      .uart_rx_byte      (uart_rx_byte)
   );

   // ---------------- UART model: TX sink and RX byte source ----------------
   logic [7:0] tx_mem [0:255];
   logic [7:0] rx_mem [0:255];
   int         tx_cnt = 0;
   int         rx_wr  = 0;
   int         rx_rd  = 0;
   logic [7:0] rx_byte_q = 8'h00;

   assign uart_rx_ready = (rx_rd != rx_wr);
   assign uart_rx_byte  = rx_byte_q;

   always @(posedge clk) begin
      if (uart_rx_read && (rx_rd != rx_wr)) begin
         rx_byte_q <= rx_mem[rx_rd[7:0]];
         rx_rd     <= rx_rd + 1;
      end
      if (uart_tx_start) begin
         tx_mem[tx_cnt[7:0]] <= uart_tx_data_in;
         tx_cnt              <= tx_cnt + 1;
      end
   end

   // ---------------- event monitors ----------------
   int cyc = 0, last_rd_cyc = 0, rsp_cyc = 0;
   int rsp_cnt = 0, stray_cnt = 0, start_cnt = 0, full_push = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (uart_rx_read) last_rd_cyc <= cyc;
      if (rsp_valid) begin
         rsp_cyc <= cyc;
         rsp_cnt <= rsp_cnt + 1;
      end
      if (stray_byte) stray_cnt <= stray_cnt + 1;
      if (uart_tx_start) start_cnt <= start_cnt + 1;
      if (uart_tx_start && uart_tx_fifo_full) full_push <= full_push + 1;
   end

   // ---------------- checks ----------------
   task automatic check_frame(input string tag, input logic [SFB-1:0] obs,
                              input logic [SFB-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // ---------------- stimulus helpers ----------------
   function automatic logic [SFB-1:0] mk(input logic [14:0] addr, input logic rw,
                                         input logic [127:0] payload);
      return {payload, addr, rw};
   endfunction

   task automatic send_cmd(input logic [SFB-1:0] frame);
      @(negedge clk);
      check_bit("cmd_ready_before_accept", cmd_ready, 1'b1);
      cmd_frame = frame;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic push_bytes(input logic [SFB-1:0] frame, input int nbytes);
      for (int k = 0; k < nbytes; k++) begin
         rx_mem[rx_wr[7:0]] = frame[SFB-1-8*k -: 8];
         rx_wr++;
      end
   endtask

   task automatic wait_tx(input string tag, input int target);
      for (int i = 0; i < 2000 && tx_cnt < target; i++) @(negedge clk);
      check_int(tag, tx_cnt, target);
   endtask

   task automatic wait_rsp(input string tag);
      for (int i = 0; i < 3000 && !rsp_valid; i++) @(negedge clk);
      check_bit(tag, rsp_valid, 1'b1);
   endtask

   function automatic logic [SFB-1:0] tx_frame(input int base);
      logic [SFB-1:0] f = '0;
      for (int k = 0; k < SFB/8; k++) begin
         int p = base + k;
         f = {f[SFB-9:0], tx_mem[p[7:0]]};
      end
      return f;
   endfunction

   // Full transaction: command out, full reply back. With poke set, a
   // different command is offered while busy and must be ignored.
   task automatic run_txn(input string tag, input logic [SFB-1:0] cmd,
                          input logic [SFB-1:0] reply, input bit poke);
      int base = tx_cnt;
      send_cmd(cmd);
      check_bit({tag, "_busy"}, busy, 1'b1);
      if (poke) begin
         cmd_frame = ~cmd;
         cmd_valid = 1'b1;
         repeat (6) @(negedge clk);
         cmd_valid = 1'b0;
      end
      wait_tx({tag, "_tx_count"}, base + 18);
      check_frame({tag, "_tx_frame"}, tx_frame(base), cmd);
      push_bytes(reply, 18);
      wait_rsp({tag, "_rsp_valid"});
      check_frame({tag, "_rsp_frame"}, rsp_frame, reply);
      check_bit({tag, "_rsp_timeout"}, rsp_timeout, 1'b0);
      check_bit({tag, "_busy_done"}, busy, 1'b0);
      @(negedge clk);
   endtask

   localparam logic [127:0] IDENT = 128'h12345678_11223344_55667788_99AABBCC;
   localparam logic [127:0] NODE  = 128'hFEDCBA98_76543210_00112233_44556677;
   localparam logic [127:0] WDATA = 128'hAABBCCDD_EEFF0011_22334455_66778899;
   localparam logic [127:0] EDATA = 128'h01020304_05060708_090A0B0C_0D0E0F10;

   initial begin
      logic [SFB-1:0] cmd, rep;
      int base, s0, r0;

      // ---- reset state ----
      repeat (3) @(negedge clk);
      check_frame("rst_rsp_frame", rsp_frame, '0);
      check_bit("rst_rsp_valid", rsp_valid, 1'b0);
      check_bit("rst_rsp_timeout", rsp_timeout, 1'b0);
      check_bit("rst_busy", busy, 1'b0);
      check_bit("rst_tx_start", uart_tx_start, 1'b0);
      check_bit("rst_rx_read", uart_rx_read, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);
      check_bit("rst_cmd_ready", cmd_ready, 1'b1);

      // ---- enumeration: broadcast, chain increments the address field ----
      cmd = mk(15'h7FFF, 1'b0, 128'h1234);
      rep = mk(15'h7FFF, 1'b0, 128'h1235);
      run_txn("enum", cmd, rep, 1'b0);
      check_int("enum_addr_field", int'(rsp_frame[30:16]), 32'h1235);
      check_int("enum_bcast", int'(rsp_frame[15:1]), 32'h7FFF);

      // ---- identity read ----
      run_txn("ident", mk(15'h1234, 1'b0, 128'h00), mk(15'h1234, 1'b0, IDENT), 1'b0);
      check_frame("ident_payload", {16'h0, rsp_frame[143:16]}, {16'h0, IDENT});

      // ---- node read, then read of an absent address (frame unchanged) ----
      run_txn("node", mk(15'h1234, 1'b0, 128'hFF), mk(15'h1234, 1'b0, NODE), 1'b0);
      cmd = mk(15'h1233, 1'b0, 128'h00);
      run_txn("absent", cmd, cmd, 1'b0);

      // ---- write echoed, with a second command offered while busy ----
      cmd = mk(15'h1234, 1'b1, WDATA);
      run_txn("write", cmd, cmd, 1'b1);

      // ---- TX backpressure, then partial reply and timeout ----
      uart_tx_fifo_full = 1'b1;
      base = tx_cnt;
      s0   = start_cnt;
      cmd  = mk(15'h1234, 1'b0, 128'h00);
      send_cmd(cmd);
      repeat (50) @(negedge clk);
      check_int("bp_no_start", start_cnt - s0, 0);
      check_bit("bp_busy", busy, 1'b1);
      uart_tx_fifo_full = 1'b0;
      wait_tx("bp_tx_count", base + 18);
      check_frame("bp_tx_frame", tx_frame(base), cmd);
      check_int("bp_no_push_when_full", full_push, 0);
      push_bytes(mk(15'h1234, 1'b0, EDATA), 5);
      wait_rsp("to_rsp_valid");
      check_bit("to_flag", rsp_timeout, 1'b1);
      check_frame("to_partial", rsp_frame, 144'h01_02030405);
      @(negedge clk);
      // Last byte: RX_READ, RX_HOLD, RX_CAPTURE, then 200 idle cycles.
      check_int("to_latency", rsp_cyc - last_rd_cyc, 3 + TMO);
      repeat (5) @(negedge clk);
      check_frame("to_frame_stable", rsp_frame, 144'h01_02030405);
      check_bit("to_flag_stable", rsp_timeout, 1'b1);

      // ---- unsolicited byte while idle ----
      s0 = stray_cnt;
      push_bytes({8'hAB, 136'h0}, 1);
      repeat (10) @(negedge clk);
      check_int("stray_pulses", stray_cnt - s0, 1);
      check_int("stray_drained", rx_wr - rx_rd, 0);
      check_bit("stray_cmd_ready", cmd_ready, 1'b1);
      check_frame("stray_frame_kept", rsp_frame, 144'h01_02030405);

      // ---- reset in the middle of the reply ----
      r0   = rsp_cnt;
      base = tx_cnt;
      send_cmd(mk(15'h1234, 1'b0, 128'h00));
      wait_tx("mr_tx_count", base + 18);
      push_bytes(mk(15'h1234, 1'b0, IDENT), 5);
      for (int i = 0; i < 200 && rx_rd != rx_wr; i++) @(negedge clk);
      repeat (4) @(negedge clk);
      check_bit("mr_busy_before", busy, 1'b1);
      rst_n = 1'b0;
      @(negedge clk);
      check_frame("mr_rsp_frame", rsp_frame, '0);
      check_bit("mr_busy", busy, 1'b0);
      check_bit("mr_rsp_valid", rsp_valid, 1'b0);
      check_bit("mr_rsp_timeout", rsp_timeout, 1'b0);
      check_bit("mr_rx_read", uart_rx_read, 1'b0);
      check_bit("mr_tx_start", uart_tx_start, 1'b0);
      check_bit("mr_stray", stray_byte, 1'b0);
      check_int("mr_tx_data", int'(uart_tx_data_in), 0);
      rst_n = 1'b1;
      repeat (300) @(negedge clk);
      check_int("mr_no_rsp", rsp_cnt - r0, 0);
      check_bit("mr_cmd_ready", cmd_ready, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
